// File: rtl/gpio_in_debounce.sv
// Per-bit synchroniser, debounce filter and sticky rise/fall event capture
// feeding the GPIO peripheral input register, with a single level interrupt.
module gpio_in_debounce #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 15,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] gpio_in_o,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] pend_clr_i,
    output logic [WIDTH-1:0] pend_o,
    output logic             irq_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d_reg;
    logic [WIDTH-1:0] pend_reg;
    logic [WIDTH-1:0] pend_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // Plain two-flop synchroniser: nothing may sit between s1 and s2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= pin_i;
            s2_reg <= s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             stable_reg;
            logic             stable_next;

            // Any sample matching the accepted level restarts the count,
            // so only an uninterrupted run of DB_CYCLES differing samples flips.
            always_comb begin
                stable_next = stable_reg;
                cnt_next    = '0;
                if (s2_reg[gi] != stable_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        stable_next = s2_reg[gi];
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    stable_reg <= stable_next;
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    assign rise = stable & ~stable_d_reg & rise_en_i;
    assign fall = ~stable & stable_d_reg & fall_en_i;

    // A new event in the same cycle as a clear wins.
    assign pend_next = (pend_reg & ~pend_clr_i) | rise | fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d_reg <= '0;
            pend_reg     <= '0;
        end else begin
            stable_d_reg <= stable;
            pend_reg     <= pend_next;
        end
    end

    assign gpio_in_o = stable;
    assign pend_o    = pend_reg;
    assign irq_o     = |pend_reg;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench: the driver pushes per-cycle expected outputs into a queue,
// and an independent monitor pops and compares one entry after every clock edge.
module tb_gpio_in_debounce;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pin_i = 8'h00;
    logic [7:0] gpio_in_o;
    logic [7:0] rise_en_i = 8'h00;
    logic [7:0] fall_en_i = 8'h00;
    logic [7:0] pend_clr_i = 8'h00;
    logic [7:0] pend_o;
    logic       irq_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] p;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    gpio_in_debounce #(.WIDTH(8), .DB_CYCLES(15), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pin_i      (pin_i),
        .gpio_in_o  (gpio_in_o),
        .rise_en_i  (rise_en_i),
        .fall_en_i  (fall_en_i),
        .pend_clr_i (pend_clr_i),
        .pend_o     (pend_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: one expected entry per clock edge while the driver is feeding the queue.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("gpio_in_o", gpio_in_o, mon_e.g);
            check("pend_o", pend_o, mon_e.p);
            check("irq_o", {7'b0, irq_o}, {7'b0, |mon_e.p});
            $display("cyc %0d pin=%h gpio=%h pend=%h irq=%b", cyc, pin_i, gpio_in_o, pend_o, irq_o);
        end
    end

    task automatic step(input logic rst, input logic [7:0] pin, input logic [7:0] clr,
                        input logic [7:0] g, input logic [7:0] p);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        pin_i      = pin;
        pend_clr_i = clr;
        e.g = g;
        e.p = p;
        exp_q.push_back(e);
    endtask

    // Hold pin for n cycles; outputs switch from *0 to *1 at edge index ge / pe (1-based).
    task automatic seg(input logic rst, input logic [7:0] pin, input int n,
                       input logic [7:0] g0, input logic [7:0] g1, input int ge,
                       input logic [7:0] p0, input logic [7:0] p1, input int pe);
        for (int k = 1; k <= n; k++)
            step(rst, pin, 8'h00, (k >= ge) ? g1 : g0, (k >= pe) ? p1 : p0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset hold, then idle.
        seg(1'b0, 8'h00, 3, 8'h00, 8'h00, 99, 8'h00, 8'h00, 99);
        seg(1'b1, 8'h00, 50, 8'h00, 8'h00, 99, 8'h00, 8'h00, 99);

        // Rise event on bit 0: level at edge 17, pending at edge 18.
        rise_en_i = 8'h01;
        seg(1'b1, 8'h01, 20, 8'h00, 8'h01, 17, 8'h00, 8'h01, 18);
        step(1'b1, 8'h01, 8'h01, 8'h01, 8'h00);

        // Glitch rejection on bit 3, then a 16-cycle pulse that is accepted.
        rise_en_i = 8'hFF;
        fall_en_i = 8'hFF;
        seg(1'b1, 8'h09, 10, 8'h01, 8'h01, 99, 8'h00, 8'h00, 99);
        seg(1'b1, 8'h01, 20, 8'h01, 8'h01, 99, 8'h00, 8'h00, 99);
        seg(1'b1, 8'h09, 16, 8'h01, 8'h01, 99, 8'h00, 8'h00, 99);
        seg(1'b1, 8'h01, 16, 8'h09, 8'h09, 99, 8'h00, 8'h08, 2);
        seg(1'b1, 8'h01, 10, 8'h09, 8'h01, 1, 8'h08, 8'h08, 99);
        step(1'b1, 8'h01, 8'h08, 8'h01, 8'h00);

        // Enable masking on bit 7: rise ignored, fall recorded.
        rise_en_i = 8'h00;
        fall_en_i = 8'h80;
        seg(1'b1, 8'h81, 20, 8'h01, 8'h81, 17, 8'h00, 8'h00, 99);
        seg(1'b1, 8'h01, 20, 8'h81, 8'h01, 17, 8'h00, 8'h80, 18);
        step(1'b1, 8'h01, 8'h80, 8'h01, 8'h00);

        // Clear in the same cycle as a new fall event: the set wins.
        seg(1'b1, 8'h81, 20, 8'h01, 8'h81, 17, 8'h00, 8'h00, 99);
        seg(1'b1, 8'h01, 17, 8'h81, 8'h01, 17, 8'h00, 8'h00, 99);
        step(1'b1, 8'h01, 8'h80, 8'h01, 8'h80);
        seg(1'b1, 8'h01, 3, 8'h01, 8'h01, 99, 8'h80, 8'h80, 99);

        // Build pend = 0x81, then start a bit-1 count and reset mid-way.
        fall_en_i = 8'h81;
        rise_en_i = 8'h02;
        seg(1'b1, 8'h00, 20, 8'h01, 8'h00, 17, 8'h80, 8'h81, 18);
        seg(1'b1, 8'h02, 8, 8'h00, 8'h00, 99, 8'h81, 8'h81, 99);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_gpio", gpio_in_o, 8'h00);
        check("async_rst_pend", pend_o, 8'h00);
        check("async_rst_irq", {7'b0, irq_o}, 8'h00);
        $display("async reset: gpio=%h pend=%h irq=%b", gpio_in_o, pend_o, irq_o);
        seg(1'b0, 8'h02, 3, 8'h00, 8'h00, 99, 8'h00, 8'h00, 99);
        // Full count required again after release.
        seg(1'b1, 8'h02, 20, 8'h00, 8'h02, 17, 8'h00, 8'h02, 18);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
